tilemap_access_arbiter: RTL and testbench
=========================================

// Module: tilemap_access_arbiter
// PURPOSE
//  Owns the single-port tile-map RAM (one 5-bit tile code per 16x16 cell, 40x30 grid at 640x480).
//  Shares it between the pixel renderer (read, absolute priority) and the Avalon CPU slave (buffered writes).
//  Sequences a full-map clear command issued by the CPU.
//  Sits between the HPS bridge and the sprite renderer.
// PARAMETERS
//  COLS         40  grid columns
//  ROWS         30  grid rows
//  CODE_W       5   tile code width (0 = empty)
//  FIFO_DEPTH   4   CPU write buffer entries (power of 2)
//  STARVE_LIMIT 64  cycles a non-empty FIFO may wait before starve_err sets
// PORTS
//  clk          in   1       50 MHz system clock
//  reset        in   1       asynchronous, active-high
//  chipselect   in   1       Avalon slave select
//  write        in   1       Avalon write strobe
//  address      in   11      tile index row*COLS+col; 11'h7FF = command register
//  writedata    in   8       [4:0] tile code; at 11'h7FF, [7]=1 requests clear to code [4:0]
//  waitrequest  out  1       Avalon stall
//  rd_req       in   1       renderer read request
//  rd_col       in   6       renderer column
//  rd_row       in   5       renderer row
//  rd_valid     out  1       rd_code valid
//  rd_code      out  CODE_W  tile code read
//  mem_addr     out  11      RAM address
//  mem_we       out  1       RAM write enable
//  mem_wdata    out  CODE_W  RAM write data
//  mem_rdata    in   CODE_W  RAM read data, 1-cycle synchronous latency
//  busy         out  1       clear sequence in progress
//  starve_err   out  1       sticky starvation flag
// BEHAVIOUR
//  Reset: FIFO empty, clear idle, rd_valid=0, rd_code=0, busy=0, starve_err=0, mem_we=0.
//    Every output is 0 while reset is asserted.
//  waitrequest = fifo_full | busy, combinational.
//  Write acceptance: a write is accepted when chipselect & write & !waitrequest.
//    Each accepted write pushes {address, writedata}.
//    No push at full, even if a pop occurs in the same cycle.
//  mem_* are combinational from the current cycle's grant. Priority: rd_req > clear step > FIFO pop.
//  Renderer grant:
//    mem_addr = rd_row*COLS + rd_col, mem_we = 0.
//    rd_valid/rd_code are registered and valid in cycle N+2 for rd_req in cycle N.
//    Back-to-back requests are fully pipelined.
//  Out-of-range renderer request (rd_col>=COLS or rd_row>=ROWS):
//    no RAM access (cycle free for others), rd_valid at N+2 with rd_code=0.
//  FIFO pop (no rd_req, not busy, FIFO non-empty):
//    - Tile entry with index < COLS*ROWS: mem_we=1, mem_addr=index, mem_wdata=data[4:0].
//    - Tile entry with index in COLS*ROWS..11'h7FE: popped and discarded, no write.
//    - Command entry with [7]=1: popped; busy=1 next cycle; clear counter=0; clear code latched.
//    - Command entry with [7]=0: discarded.
//    A push of an entry is visible for pop the cycle after acceptance.
//  Clear FSM: IDLE -> CLEAR -> IDLE.
//    In CLEAR, each cycle without rd_req writes the clear code at counter, then increments it.
//    After writing index COLS*ROWS-1, the FSM returns to IDLE and busy falls the next cycle.
//    rd_req cycles stall the counter without skipping an index.
//  FIFO ordering: order is preserved, so a clear follows all earlier writes and precedes later ones.
//  Starvation: starve counter counts cycles with FIFO non-empty and no pop; it is cleared on a pop.
//    At STARVE_LIMIT, starve_err sets and holds until reset.
//  Reset mid-operation: an in-flight clear or FIFO contents are discarded, with no further RAM writes.
// TESTING
//  1. Release reset, all inputs idle -> all outputs 0, waitrequest=0 for 20 cycles.
//  2. Write idx 41 code 3 in cycle N, rd_req idle -> mem_we=1, addr 41, wdata 3 in N+1.
//     Then rd_req col1 row1 -> rd_valid, rd_code=3 two cycles later.
//  3. rd_req held 12 cycles; CPU writes 5 tiles.
//     -> waitrequest rises after 4 accepted; mem_we=0 in every rd_req cycle.
//     -> All 5 written in order after rd_req drops; starve_err stays 0.
//  4. Write 11'h7FF data 8'h80, renderer reads every other cycle.
//     -> busy high; 1200 writes of code 0 at idx 0..1199, no gaps or repeats.
//     -> waitrequest high throughout; busy low after idx 1199.
//  5. rd col 45 row 2 -> rd_code=0, rd_valid at N+2, mem_we free that cycle.
//     Write idx 1500 -> accepted, no mem_we.
//  6. Hold rd_req 70 cycles with FIFO non-empty -> starve_err=1 at cycle 64.
//     Assert reset mid-clear -> busy=0, FIFO empty, no mem_we after release.

Source files
------------

// File: rtl/tilemap_access_if.sv
// CPU (Avalon slave) and renderer read port of the tile-map access arbiter.
// The master modport drives requests; the slave modport is the arbiter side.
interface tilemap_access_if #(
    parameter int unsigned CODE_W = 5
);
    logic              chipselect;
    logic              write;
    logic [10:0]       address;
    logic [7:0]        writedata;
    logic              waitrequest;
    logic              rd_req;
    logic [5:0]        rd_col;
    logic [4:0]        rd_row;
    logic              rd_valid;
    logic [CODE_W-1:0] rd_code;

    modport master (
        output chipselect, write, address, writedata, rd_req, rd_col, rd_row,
        input  waitrequest, rd_valid, rd_code
    );

    modport slave (
        input  chipselect, write, address, writedata, rd_req, rd_col, rd_row,
        output waitrequest, rd_valid, rd_code
    );
endinterface

// File: rtl/tilemap_access_arbiter.sv
// Single-port tile-map RAM arbiter: renderer reads win, then clear steps, then
// buffered CPU writes. A CPU command entry launches a full-map clear sequence.
module tilemap_access_arbiter #(
    parameter int unsigned COLS         = 40,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned CODE_W       = 5,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    tilemap_access_if.slave   bus,
    output logic [10:0]       mem_addr,
    output logic              mem_we,
    output logic [CODE_W-1:0] mem_wdata,
    input  logic [CODE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              starve_err
);
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [10:0] CMD_ADDR = 11'h7FF;
    localparam logic [10:0] LAST_IDX = 11'(CELLS - 1);

    typedef struct packed {
        logic [10:0]       addr;
        logic              clr;
        logic [CODE_W-1:0] code;
    } entry_t;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            state, state_next;
    entry_t            fifo_mem [FIFO_DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [10:0]       clr_cnt, clr_cnt_next;
    logic [CODE_W-1:0] clr_code, clr_code_next;
    logic [SW-1:0]     starve_cnt;
    logic              rd_req_d, rd_hit_d;
    logic              fifo_full, fifo_empty, push, pop, rd_hit;
    logic [10:0]       rd_addr;

    assign fifo_full       = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty      = (count == '0);
    assign busy            = (state == S_CLEAR);
    assign bus.waitrequest = fifo_full | busy;
    assign push            = bus.chipselect & bus.write & ~bus.waitrequest;
    assign head            = fifo_mem[rd_ptr];
    assign rd_hit          = bus.rd_req && (bus.rd_col < 6'(COLS)) && (bus.rd_row < 5'(ROWS));
    assign rd_addr         = 11'(bus.rd_row) * 11'(COLS) + 11'(bus.rd_col);

    // Clear sequencer state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            clr_cnt  <= '0;
            clr_code <= '0;
        end else begin
            state    <= state_next;
            clr_cnt  <= clr_cnt_next;
            clr_code <= clr_code_next;
        end
    end

    // Per-cycle grant: renderer, else clear step, else FIFO pop
    always_comb begin
        state_next    = state;
        clr_cnt_next  = clr_cnt;
        clr_code_next = clr_code;
        pop           = 1'b0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        if (rd_hit) begin
            mem_addr = rd_addr;
        end else begin
            case (state)
                S_CLEAR: begin
                    mem_addr  = clr_cnt;
                    mem_we    = 1'b1;
                    mem_wdata = clr_code;
                    if (clr_cnt == LAST_IDX) state_next   = S_IDLE;
                    else                     clr_cnt_next = clr_cnt + 11'd1;
                end
                default: begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        mem_addr = head.addr;
                        if (head.addr == CMD_ADDR) begin
                            if (head.clr) begin
                                state_next    = S_CLEAR;
                                clr_cnt_next  = '0;
                                clr_code_next = head.code;
                            end
                        end else if (head.addr < 11'(CELLS)) begin
                            mem_we    = 1'b1;
                            mem_wdata = head.code;
                        end
                    end
                end
            endcase
        end
        if (reset) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= entry_t'{bus.address, bus.writedata[7], bus.writedata[CODE_W-1:0]};
    end

    // FIFO pointers; a pop at full does not make room for a same-cycle push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Starvation watchdog: counts waiting cycles of a non-empty FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            starve_err <= 1'b0;
        end else begin
            if (pop)                                               starve_cnt <= '0;
            else if (!fifo_empty && starve_cnt < SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
            if (!pop && !fifo_empty && starve_cnt >= SW'(STARVE_LIMIT - 1)) starve_err <= 1'b1;
        end
    end

    // Read return: RAM data arrives one cycle after the request, registered once more
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_req_d     <= 1'b0;
            rd_hit_d     <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_code  <= '0;
        end else begin
            rd_req_d     <= bus.rd_req;
            rd_hit_d     <= rd_hit;
            bus.rd_valid <= rd_req_d;
            bus.rd_code  <= rd_hit_d ? mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_tilemap_access_arbiter.sv
// Bench for tilemap_access_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based transaction model.
`timescale 1ns/1ps
module tb_tilemap_access_arbiter;
    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int DEPTH = 4;
    localparam int LIMIT = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [10:0] mem_addr;
    logic       mem_we;
    logic [4:0] mem_wdata;
    logic [4:0] mem_rdata = '0;
    logic       busy, starve_err;

    tilemap_access_if #(.CODE_W(5)) bus ();

    tilemap_access_arbiter #(
        .COLS(COLS), .ROWS(ROWS), .CODE_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .starve_err(starve_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Synchronous RAM with one-cycle read latency
    logic [4:0] ram [2048];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Transaction model state
    logic [18:0] mq [$];
    bit          m_clear = 0;
    int          m_idx = 0;
    int          m_code = 0;
    int          m_starve = 0;
    bit          m_err = 0;
    logic [4:0]  m_map [CELLS];
    bit          p0_v = 0, p1_v = 0;
    int          p0_c = 0, p1_c = 0;

    always @(negedge clk) begin
        bit hit, nonempty, popped, e_wait, e_we;
        int e_addr, e_data, ridx;
        logic [18:0] ent;
        logic [10:0] a;
        logic [7:0]  d;
        if (reset) begin
            chk("rst_wait", bus.waitrequest, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            chk("rst_valid", bus.rd_valid, 0);
            chk("rst_code", bus.rd_code, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", starve_err, 0);
            mq.delete();
            m_clear = 0; m_starve = 0; m_err = 0;
            p0_v = 0; p1_v = 0; p0_c = 0; p1_c = 0;
        end else begin
            e_wait = (mq.size() == DEPTH) || m_clear;
            chk("waitrequest", bus.waitrequest, e_wait);
            chk("busy", busy, m_clear);
            chk("starve_err", starve_err, m_err);
            chk("rd_valid", bus.rd_valid, p1_v);
            if (p1_v) chk("rd_code", bus.rd_code, p1_c);

            hit      = bus.rd_req && bus.rd_col < COLS && bus.rd_row < ROWS;
            ridx     = int'(bus.rd_row) * COLS + int'(bus.rd_col);
            nonempty = mq.size() != 0;
            popped   = 0;
            e_we     = 0;
            e_addr   = 0;
            e_data   = 0;
            if (hit) begin
                chk("rd_mem_we", mem_we, 0);
                chk("rd_mem_addr", mem_addr, ridx);
            end else if (m_clear) begin
                e_we = 1; e_addr = m_idx; e_data = m_code;
                m_map[m_idx] = 5'(m_code);
                m_idx++;
                if (m_idx == CELLS) m_clear = 0;
            end else if (nonempty) begin
                popped = 1;
                ent = mq.pop_front();
                a = ent[18:8];
                d = ent[7:0];
                if (a == 11'h7FF) begin
                    if (d[7]) begin m_clear = 1; m_idx = 0; m_code = int'(d[4:0]); end
                end else if (a < CELLS) begin
                    e_we = 1; e_addr = int'(a); e_data = int'(d[4:0]);
                    m_map[a] = d[4:0];
                end
            end
            if (!hit) begin
                chk("mem_we", mem_we, e_we);
                if (e_we) begin
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_wdata", mem_wdata, e_data);
                end
            end
            if (bus.chipselect && bus.write && !e_wait) mq.push_back({bus.address, bus.writedata});
            if (popped)        m_starve = 0;
            else if (nonempty) m_starve++;
            if (m_starve >= LIMIT) m_err = 1;
            p1_v = p0_v; p1_c = p0_c;
            p0_v = bus.rd_req;
            p0_c = hit ? int'(m_map[ridx]) : 0;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.chipselect = 0; bus.write = 0; bus.address = '0; bus.writedata = '0;
        bus.rd_req = 0; bus.rd_col = '0; bus.rd_row = '0;
    endtask

    task automatic read_tile(input int col, input int row, input int exp, input string name);
        cycle();
        bus.rd_req = 1; bus.rd_col = 6'(col); bus.rd_row = 5'(row);
        cycle();
        bus.rd_req = 0;
        cycle();
        @(negedge clk);
        chk({name, "_valid"}, bus.rd_valid, 1);
        chk(name, bus.rd_code, exp);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, nidx, r;
        bit seen_busy;
        for (int i = 0; i < 2048; i++) ram[i] = '0;
        for (int i = 0; i < CELLS; i++) m_map[i] = '0;
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Idle after reset
        repeat (20) begin
            @(negedge clk);
            chk("t1_wait", bus.waitrequest, 0);
            chk("t1_we", mem_we, 0);
            chk("t1_valid", bus.rd_valid, 0);
            chk("t1_busy", busy, 0);
            chk("t1_err", starve_err, 0);
        end

        // Single write then read back
        cycle();
        bus.chipselect = 1; bus.write = 1; bus.address = 11'd41; bus.writedata = 8'd3;
        cycle();
        idle();
        @(negedge clk);
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 41);
        chk("t2_wdata", mem_wdata, 3);
        read_tile(1, 1, 3, "t2_read");

        // Writes queued behind a long renderer burst
        acc = 0;
        for (int c = 0; c < 40 && acc < 5; c++) begin
            cycle();
            bus.rd_req = (c < 12); bus.rd_col = '0; bus.rd_row = '0;
            bus.chipselect = 1; bus.write = 1;
            bus.address = 11'(100 + acc); bus.writedata = 8'(10 + acc);
            @(negedge clk);
            if (c < 12) chk("t3_we_in_rd", mem_we, 0);
            if (c == 4) chk("t3_wait_full", bus.waitrequest, 1);
            if (!bus.waitrequest) acc++;
        end
        cycle();
        idle();
        for (int c = 0; c < 20 && mq.size() != 0; c++) cycle();
        chk("t3_drained", mq.size(), 0);
        for (int i = 0; i < 5; i++) read_tile(20 + i, 2, 10 + i, "t3_read");
        @(negedge clk);
        chk("t3_err", starve_err, 0);

        // Full-map clear with interleaved renderer reads
        cycle();
        bus.chipselect = 1; bus.write = 1; bus.address = 11'h7FF; bus.writedata = 8'h80;
        cycle();
        idle();
        nidx = 0; seen_busy = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.rd_req = c[0]; bus.rd_col = 6'($urandom_range(0, 39)); bus.rd_row = 5'($urandom_range(0, 29));
            @(negedge clk);
            if (busy) begin seen_busy = 1; chk("t4_wait", bus.waitrequest, 1); end
            if (mem_we) begin
                chk("t4_idx", mem_addr, nidx);
                chk("t4_code", mem_wdata, 0);
                nidx++;
            end
            if (seen_busy && !busy) break;
            cycle();
        end
        chk("t4_count", nidx, CELLS);
        chk("t4_seen_busy", seen_busy, 1);
        cycle();
        idle();
        read_tile(1, 1, 0, "t4_read_cleared");

        // Out-of-range read leaves the RAM slot to a pending write
        cycle();
        bus.chipselect = 1; bus.write = 1; bus.address = 11'd7; bus.writedata = 8'd9;
        cycle();
        idle();
        bus.rd_req = 1; bus.rd_col = 6'd45; bus.rd_row = 5'd2;
        @(negedge clk);
        chk("t5_free_we", mem_we, 1);
        chk("t5_free_addr", mem_addr, 7);
        cycle();
        bus.rd_req = 0;
        cycle();
        @(negedge clk);
        chk("t5_valid", bus.rd_valid, 1);
        chk("t5_code", bus.rd_code, 0);
        cycle();
        bus.chipselect = 1; bus.write = 1; bus.address = 11'd1500; bus.writedata = 8'd4;
        @(negedge clk);
        chk("t5_accept", bus.waitrequest, 0);
        cycle();
        idle();
        @(negedge clk);
        chk("t5_no_we", mem_we, 0);

        // Starvation under a 70-cycle renderer burst
        cycle();
        bus.chipselect = 1; bus.write = 1; bus.address = 11'd200; bus.writedata = 8'd6;
        cycle();
        idle();
        bus.rd_req = 1; bus.rd_col = 6'd3; bus.rd_row = 5'd3;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (c == 63) chk("t6_err_early", starve_err, 0);
            if (c == 64) chk("t6_err_set", starve_err, 1);
            cycle();
        end
        idle();
        repeat (5) cycle();
        @(negedge clk);
        chk("t6_err_hold", starve_err, 1);

        // Reset in the middle of a clear
        cycle();
        bus.chipselect = 1; bus.write = 1; bus.address = 11'h7FF; bus.writedata = 8'h85;
        cycle();
        idle();
        repeat (50) cycle();
        @(negedge clk);
        chk("t6_busy_mid", busy, 1);
        cycle();
        reset = 1;
        @(negedge clk);
        chk("t6_rst_busy", busy, 0);
        cycle();
        reset = 0;
        repeat (20) begin
            @(negedge clk);
            chk("t6_post_we", mem_we, 0);
            chk("t6_post_busy", busy, 0);
            chk("t6_post_err", starve_err, 0);
            cycle();
        end
        read_tile(10, 0, 5, "t6_read_partial");
        read_tile(10, 10, 0, "t6_read_untouched");

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            cycle();
            reset = ($urandom_range(0, 999) == 0);
            bus.rd_req = 1'($urandom_range(0, 1));
            bus.rd_col = 6'($urandom_range(0, 44));
            bus.rd_row = 5'($urandom_range(0, 31));
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.write = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 80)      bus.address = 11'($urandom_range(0, CELLS - 1));
            else if (r < 92) bus.address = 11'($urandom_range(CELLS, 2046));
            else             bus.address = 11'h7FF;
            bus.writedata = 8'($urandom);
            if (bus.address == 11'h7FF && $urandom_range(0, 7) != 0) bus.writedata[7] = 1'b0;
        end
        cycle();
        reset = 0;
        idle();
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
